iter_muldiv_unit: RTL and testbench

- Multi-cycle 64-bit multiply/divide execute unit.
- Consumes the two register-file read operands (rd1 -> op_a, rd2 -> op_b).
- Produces MUL/UMULH/UDIV/SDIV results with a destination address and write strobe for the register-file write port (wa3/wd3/we3).
- The control unit stalls the PC while busy is high.

---
 rtl/iter_muldiv_unit.sv | 160 ++++++++++++++++
 tb/tb_iter_muldiv_unit.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/iter_muldiv_unit.sv
// Iterative 64-bit MUL/UMULH/UDIV/SDIV unit: one shift-add or restoring-divide step per cycle.
// Optional macro MULDIV_EARLY_OUT_EN finishes zero-operand cases in one cycle.
module iter_muldiv_unit #(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [WIDTH-1:0]  op_a,
  input  logic [WIDTH-1:0]  op_b,
  input  logic [ADDR_W-1:0] dst,
  output logic              busy,
  output logic              done,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_wa,
  output logic [WIDTH-1:0]  wb_wd
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_SDIV = 2'b11;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIXUP, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          op_q, op_d;
  logic [ADDR_W-1:0]   dst_q, dst_d;
  logic [WIDTH-1:0]    hi_q, hi_d;    // product high half / partial remainder
  logic [WIDTH-1:0]    lo_q, lo_d;    // multiplier bits / quotient bits
  logic [WIDTH-1:0]    opnd_q, opnd_d; // multiplicand / divisor magnitude
  logic                neg_q, neg_d;
  logic                bzero_q, bzero_d;
  logic [WIDTH-1:0]    wd_q, wd_d;

  logic                accept;
  logic                early;
  logic [WIDTH:0]      mul_sum;
  logic [WIDTH:0]      div_shift;
  logic [WIDTH:0]      div_diff;

  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v);
    return v[WIDTH-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] mag, input logic neg);
    return neg ? (~mag + 1'b1) : mag;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    dst_d     = dst_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    neg_d     = neg_q;
    bzero_d   = bzero_q;
    wd_d      = wd_q;
    accept    = start && (state_q == S_IDLE || state_q == S_DONE);
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
`ifdef MULDIV_EARLY_OUT_EN
    early     = (op_a == '0) || (op_b == '0);
`else
    early     = 1'b0;
`endif

    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          op_d    = op;
          dst_d   = dst;
          cnt_d   = CNT_W'(WIDTH);
          hi_d    = '0;
          bzero_d = (op_b == '0);
          neg_d   = (op == OP_SDIV) && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
          if (!op[1]) begin
            lo_d   = op_b;
            opnd_d = op_a;
          end else if (op == OP_SDIV) begin
            lo_d   = magnitude(op_a);
            opnd_d = magnitude(op_b);
          end else begin
            lo_d   = op_a;
            opnd_d = op_b;
          end
          if (early) begin
            wd_d    = '0;
            state_d = S_DONE;
          end else begin
            state_d = S_RUN;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - 1'b1;
        if (!op_q[1]) begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
        if (cnt_q == CNT_W'(1)) state_d = S_FIXUP;
      end
      S_FIXUP: begin
        // Most-negative / -1 needs no special case: its magnitude quotient already is 0x8000...
        case (op_q)
          2'b00:   wd_d = lo_q;
          2'b01:   wd_d = hi_q;
          default: wd_d = bzero_q ? '0 : apply_sign(lo_q, neg_q);
        endcase
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      dst_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      neg_q   <= 1'b0;
      bzero_q <= 1'b0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dst_q   <= dst_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      neg_q   <= neg_d;
      bzero_q <= bzero_d;
      wd_q    <= wd_d;
    end
  end

  assign busy  = (state_q == S_RUN) || (state_q == S_FIXUP);
  assign done  = (state_q == S_DONE);
  assign wb_we = done;
  assign wb_wa = dst_q;
  assign wb_wd = wd_q;

endmodule

// File: tb/tb_iter_muldiv_unit.sv
// Randomized self-checking bench for iter_muldiv_unit against a plain-arithmetic reference model.
module tb_iter_muldiv_unit;
  localparam int W        = 64;
  localparam int AW       = 5;
  localparam int FULL_LAT = W + 2;
  localparam int MAX_WAIT = 200;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [W-1:0]  op_a = '0;
  logic [W-1:0]  op_b = '0;
  logic [AW-1:0] dst = '0;
  logic          busy, done, wb_we;
  logic [AW-1:0] wb_wa;
  logic [W-1:0]  wb_wd;

  int total = 0;
  int bad   = 0;

  iter_muldiv_unit #(.WIDTH(W), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .op_a(op_a), .op_b(op_b),
    .dst(dst), .busy(busy), .done(done), .wb_we(wb_we), .wb_wa(wb_wa), .wb_wd(wb_wd)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_result(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] p;
    longint sa, sb, sq;
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    sa = a;
    sb = b;
    case (o)
      2'b00: return p[W-1:0];
      2'b01: return p[2*W-1:W];
      2'b10: return (b == 0) ? '0 : a / b;
      default: begin
        if (sb == 0) return '0;
        if (sa == 64'sh8000_0000_0000_0000 && sb == -64'sd1) return a;
        sq = sa / sb;
        return sq;
      end
    endcase
  endfunction

  function automatic int ref_latency(input logic [W-1:0] a, input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
    if (a == 0 || b == 0) return 1;
`endif
    return FULL_LAT;
  endfunction

  // Starts one operation from a post-edge position and waits for done; returns observations.
  task automatic do_op(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [AW-1:0] d, output int lat, output logic [W-1:0] wd,
                       output logic [AW-1:0] wa, output logic we, output logic busy_seen,
                       output logic pulse_ok);
    start = 1'b1; op = o; op_a = a; op_b = b; dst = d;
    @(posedge clk); #1;
    start = 1'b0; op_a = {$urandom, $urandom}; op_b = {$urandom, $urandom}; dst = AW'($urandom);
    lat = 1;
    busy_seen = busy;
    while (!done && lat < MAX_WAIT) begin
      @(posedge clk); #1;
      lat++;
      busy_seen |= busy;
    end
    wd = wb_wd; wa = wb_wa; we = wb_we;
    @(posedge clk); #1;
    pulse_ok = !done && !wb_we && (wb_wd === wd);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({busy, done, wb_we} !== 3'b000) begin bad++; $display("FAIL reset_ctrl got=%b exp=000", {busy, done, wb_we}); end
    total++; if (wb_wd !== '0) begin bad++; $display("FAIL reset_wd got=%h exp=0", wb_wd); end
    total++; if (wb_wa !== '0) begin bad++; $display("FAIL reset_wa got=%h exp=0", wb_wa); end
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if ({busy, done} !== 2'b00) begin bad++; $display("FAIL reset_release got=%b exp=00", {busy, done}); end
  endtask

  task automatic test_mul();
    int lat; logic [W-1:0] wd; logic [AW-1:0] wa; logic we, bs, po;
    do_op(2'b00, 64'd7, 64'd6, 5'd3, lat, wd, wa, we, bs, po);
    total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL mul_latency got=%0d exp=%0d", lat, FULL_LAT); end
    total++; if (wd !== 64'd42) begin bad++; $display("FAIL mul_wd got=%h exp=%h", wd, 64'd42); end
    total++; if (wa !== 5'd3 || we !== 1'b1) begin bad++; $display("FAIL mul_wa_we got=%h/%b exp=3/1", wa, we); end
    total++; if (bs !== 1'b1 || po !== 1'b1) begin bad++; $display("FAIL mul_busy_pulse got=%b/%b exp=1/1", bs, po); end
    do_op(2'b01, '1, '1, 5'd31, lat, wd, wa, we, bs, po);
    total++; if (wd !== 64'hFFFF_FFFF_FFFF_FFFE) begin bad++; $display("FAIL umulh_wd got=%h exp=fffffffffffffffe", wd); end
    total++; if (wa !== 5'd31) begin bad++; $display("FAIL umulh_wa got=%h exp=1f", wa); end
  endtask

  task automatic test_div();
    int lat; logic [W-1:0] wd; logic [AW-1:0] wa; logic we, bs, po;
    do_op(2'b10, 64'd100, 64'd7, 5'd4, lat, wd, wa, we, bs, po);
    total++; if (wd !== 64'd14) begin bad++; $display("FAIL udiv_wd got=%h exp=%h", wd, 64'd14); end
    total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL udiv_latency got=%0d exp=%0d", lat, FULL_LAT); end
    do_op(2'b11, -64'sd100, 64'd7, 5'd5, lat, wd, wa, we, bs, po);
    total++; if (wd !== 64'hFFFF_FFFF_FFFF_FFF2) begin bad++; $display("FAIL sdiv_neg got=%h exp=fffffffffffffff2", wd); end
    do_op(2'b11, 64'h8000_0000_0000_0000, '1, 5'd6, lat, wd, wa, we, bs, po);
    total++; if (wd !== 64'h8000_0000_0000_0000) begin bad++; $display("FAIL sdiv_ovf got=%h exp=8000000000000000", wd); end
  endtask

  task automatic test_zero_cases();
    int lat; logic [W-1:0] wd; logic [AW-1:0] wa; logic we, bs, po;
    do_op(2'b10, 64'd5, 64'd0, 5'd7, lat, wd, wa, we, bs, po);
    total++; if (wd !== '0) begin bad++; $display("FAIL udiv_by0 got=%h exp=0", wd); end
    total++; if (lat !== ref_latency(64'd5, 64'd0)) begin bad++; $display("FAIL udiv_by0_latency got=%0d exp=%0d", lat, ref_latency(64'd5, 64'd0)); end
    do_op(2'b11, -64'sd9, 64'd0, 5'd8, lat, wd, wa, we, bs, po);
    total++; if (wd !== '0) begin bad++; $display("FAIL sdiv_by0 got=%h exp=0", wd); end
    do_op(2'b00, 64'd0, 64'd9, 5'd9, lat, wd, wa, we, bs, po);
    total++; if (wd !== '0 || wa !== 5'd9) begin bad++; $display("FAIL mul_zero got=%h/%h exp=0/9", wd, wa); end
    total++; if (lat !== ref_latency(64'd0, 64'd9)) begin bad++; $display("FAIL mul_zero_latency got=%0d exp=%0d", lat, ref_latency(64'd0, 64'd9)); end
    total++; if (bs !== (ref_latency(64'd0, 64'd9) > 1)) begin bad++; $display("FAIL mul_zero_busy got=%b exp=%b", bs, ref_latency(64'd0, 64'd9) > 1); end
    total++; if (po !== 1'b1) begin bad++; $display("FAIL mul_zero_pulse got=%b exp=1", po); end
  endtask

  task automatic test_abort();
    logic seen_we;
    start = 1'b1; op = 2'b00; op_a = 64'd7; op_b = 64'd6; dst = 5'd12;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL abort_running got=%b exp=1", busy); end
    reset = 1'b0;
    @(posedge clk); #1;
    total++; if ({busy, done, wb_we} !== 3'b000 || wb_wd !== '0 || wb_wa !== '0) begin
      bad++; $display("FAIL abort_state got=%b/%h/%h exp=000/0/0", {busy, done, wb_we}, wb_wd, wb_wa);
    end
    reset = 1'b1;
    seen_we = 1'b0;
    repeat (FULL_LAT + 10) begin
      @(posedge clk); #1;
      seen_we |= wb_we;
    end
    total++; if (seen_we !== 1'b0) begin bad++; $display("FAIL abort_no_write got=%b exp=0", seen_we); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    start = 1'b1; op = 2'b10; op_a = 64'd100; op_b = 64'd7; dst = 5'd9;
    @(posedge clk); #1;
    lat = 1;
    while (!done && lat < MAX_WAIT) begin
      start = (lat == 20);
      op = 2'b00; op_a = 64'd5; op_b = 64'd5; dst = 5'd1;
      @(posedge clk); #1;
      lat++;
    end
    start = 1'b0;
    total++; if (wb_wd !== 64'd14 || wb_wa !== 5'd9) begin bad++; $display("FAIL ignore_start got=%h/%h exp=e/9", wb_wd, wb_wa); end
    total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL ignore_start_latency got=%0d exp=%0d", lat, FULL_LAT); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    int lat;
    start = 1'b1; op = 2'b00; op_a = 64'd3; op_b = 64'd4; dst = 5'd2;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < MAX_WAIT) begin @(posedge clk); #1; lat++; end
    total++; if (wb_wd !== 64'd12 || busy !== 1'b0) begin bad++; $display("FAIL b2b_first got=%h/%b exp=c/0", wb_wd, busy); end
    start = 1'b1; op = 2'b10; op_a = 64'd1000; op_b = 64'd10; dst = 5'd4;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    total++; if (busy !== 1'b1 || done !== 1'b0) begin bad++; $display("FAIL b2b_accept got=%b/%b exp=1/0", busy, done); end
    while (!done && lat < MAX_WAIT) begin @(posedge clk); #1; lat++; end
    total++; if (lat !== FULL_LAT) begin bad++; $display("FAIL b2b_latency got=%0d exp=%0d", lat, FULL_LAT); end
    total++; if (wb_wd !== 64'd100 || wb_wa !== 5'd4) begin bad++; $display("FAIL b2b_second got=%h/%h exp=64/4", wb_wd, wb_wa); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int lat; logic [W-1:0] wd; logic [AW-1:0] wa; logic we, bs, po;
    logic [1:0] o; logic [W-1:0] a, b, exp_wd; logic [AW-1:0] d;
    for (int i = 0; i < 20; i++) begin
      o = 2'($urandom_range(0, 3));
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      d = AW'($urandom);
      case ($urandom_range(0, 6))
        0: b = '0;
        1: b = W'($urandom_range(1, 20));
        2: a = '0;
        3: begin a = 64'h8000_0000_0000_0000; b = '1; end
        4: b = {32'd0, $urandom};
        5: b = -W'($urandom_range(1, 1000));
        default: ;
      endcase
      exp_wd = ref_result(o, a, b);
      do_op(o, a, b, d, lat, wd, wa, we, bs, po);
      total++; if (wd !== exp_wd) begin bad++; $display("FAIL rand%0d_op%0d_wd got=%h exp=%h", i, o, wd, exp_wd); end
      total++; if (lat !== ref_latency(a, b)) begin bad++; $display("FAIL rand%0d_latency got=%0d exp=%0d", i, lat, ref_latency(a, b)); end
      total++; if (wa !== d || we !== 1'b1 || po !== 1'b1) begin bad++; $display("FAIL rand%0d_wb got=%h/%b/%b exp=%h/1/1", i, wa, we, po, d); end
    end
  endtask

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_zero_cases();
    test_abort();
    test_start_while_busy();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
